// File: rtl/dma_bus_arbiter_pkg.sv
// Shared definitions for the CPU/DMA data-memory bus arbiter.
// The memory model and the DMA engine also use these constants.
package dma_bus_arbiter_pkg;

  localparam int unsigned WORD_SIZE  = 16;
  localparam int unsigned LINE_WORDS = 4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_CPU = 3'd1,
    S_GRANT    = 3'd2,
    S_HOLD     = 3'd3,
    S_GAP      = 3'd4
  } arb_state_e;

  // The DMA owns the bus in these states.
  function automatic logic is_granted(input arb_state_e s);
    return (s == S_GRANT) || (s == S_HOLD);
  endfunction

endpackage

// File: rtl/dma_bus_arbiter_line_counter.sv
// Saturating, clearable up-counter with a terminal-count flag.
// It produces the per-line DMA write offset.
module line_counter #(
  parameter int unsigned W   = 2,
  parameter int unsigned MAX = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);

  logic [W-1:0] count_q, count_d;

  assign tc_o    = (count_q == W'(MAX));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !tc_o) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Data-memory bus arbiter between CPU and DMA: BR/BG handshake, line offset
// generation, completion/abort pulses, CPU stall and memory-side selects.
module dma_bus_arbiter
  import dma_bus_arbiter_pkg::*;
#(
  parameter int NUM_LINES = 3,
  parameter int OFFSET_W  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                br,
  output logic                bg,
  input  logic                cpu_d_req,
  input  logic                cpu_mem_busy,
  input  logic                dma_write,
  output logic [OFFSET_W-1:0] offset,
  output logic                sel_dma,
  output logic                cpu_rd_en,
  output logic                cpu_wr_en,
  output logic                cpu_stall,
  output logic                xfer_done,
  output logic                abort,
  output logic                proto_err
);

  arb_state_e          state_q, state_d;
  logic                bg_q, bg_d;
  logic                xfer_q, xfer_d;
  logic                abort_q, abort_d;
  logic                perr_q, perr_d;
  logic [OFFSET_W-1:0] line_cnt;
  logic                last_line;

  // Counter idles at zero while the bus belongs to the CPU, so GRANT entry
  // always starts from line 0.
  line_counter #(
    .W   (OFFSET_W),
    .MAX (NUM_LINES - 1)
  ) u_line_counter (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (~bg_q),
    .inc_i   (dma_write && (state_q == S_GRANT)),
    .count_o (line_cnt),
    .tc_o    (last_line)
  );

  always_comb begin
    state_d = state_q;
    xfer_d  = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (br) state_d = cpu_mem_busy ? S_WAIT_CPU : S_GRANT;
      end
      S_WAIT_CPU: begin
        if (!br)                state_d = S_IDLE;
        else if (!cpu_mem_busy) state_d = S_GRANT;
      end
      S_GRANT: begin
        // A last write wins over a simultaneous release: done, not abort.
        if (dma_write && last_line) begin
          xfer_d  = 1'b1;
          state_d = br ? S_HOLD : S_GAP;
        end else if (!br) begin
          abort_d = 1'b1;
          state_d = S_GAP;
        end
      end
      S_HOLD: begin
        if (!br) state_d = S_GAP;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    bg_d   = is_granted(state_d);
    perr_d = perr_q | (dma_write & (~bg_q | (state_q == S_HOLD)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      bg_q    <= 1'b0;
      xfer_q  <= 1'b0;
      abort_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bg_q    <= bg_d;
      xfer_q  <= xfer_d;
      abort_q <= abort_d;
      perr_q  <= perr_d;
    end
  end

  assign bg        = bg_q;
  assign sel_dma   = bg_q;
  assign offset    = bg_q ? line_cnt : '0;
  assign cpu_rd_en = cpu_d_req & ~bg_q;
  assign cpu_wr_en = cpu_d_req & ~bg_q;
  assign cpu_stall = cpu_d_req & bg_q;
  assign xfer_done = xfer_q;
  assign abort     = abort_q;
  assign proto_err = perr_q;

endmodule

// File: doc/dma_bus_arbiter.md
# dma_bus_arbiter

Owns the data-memory bus shared by the CPU and the DMA engine. Runs the BR/BG handshake, grants the bus to the DMA only at a CPU memory-access boundary, and generates the per-line `offset` for DMA writes. Its select outputs replace the tri-state data-bus mux at the memory boundary. It counts line writes, signals transfer completion, and stalls the CPU while the DMA holds the bus.

## Interface
- `NUM_LINES`, 3: 4-word lines per DMA transfer; legal range 1..4.
- `OFFSET_W`, 2: width of `offset`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `br` in 1: DMA bus request; level, held high for the whole transfer.
- `bg` out 1: bus grant to the DMA; registered.
- `cpu_d_req` in 1: CPU drives `d_readM` or `d_writeM` this cycle.
- `cpu_mem_busy` in 1: CPU is inside a multi-cycle data access; it must not be split.
- `dma_write` in 1: DMA writes one line this cycle.
- `offset` out `OFFSET_W`: line index for the current DMA write.
- `sel_dma` out 1: memory write data and write-enable come from the DMA; equals `bg`.
- `cpu_rd_en` out 1: `cpu_d_req & ~bg`; gates memory read data back to the CPU.
- `cpu_wr_en` out 1: `cpu_d_req & ~bg`; gates CPU write data onto the memory bus.
- `cpu_stall` out 1: `bg & cpu_d_req`; the CPU freezes its memory stage.
- `xfer_done` out 1: one-cycle pulse after the last line write.
- `abort` out 1: one-cycle pulse when `br` drops before `NUM_LINES` writes.
- `proto_err` out 1: sticky; set by `dma_write` while `bg`=0. Cleared only by reset.

## Operation
- States:
  - IDLE: `bg`=0. Waiting for a request.
  - WAIT_CPU: `bg`=0. `br` is seen but the CPU is busy.
  - GRANT: `bg`=1. The DMA owns the bus.
  - HOLD: `bg`=1. All lines are written; waiting for `br` to drop.
  - GAP: `bg`=0. Mandatory one-cycle idle before a new grant.
- IDLE transitions:
  - `br & ~cpu_mem_busy` -> GRANT.
  - `br & cpu_mem_busy` -> WAIT_CPU.
- WAIT_CPU transitions:
  - `~br` -> IDLE, with no pulse.
  - `~cpu_mem_busy` -> GRANT.
- GRANT:
  - On entry, line counter = 0.
  - Each `dma_write` increments the counter.
  - A write with counter == `NUM_LINES-1` -> HOLD, and `xfer_done` pulses in the next cycle.
  - `~br` with the counter short -> GAP, and `abort` pulses in the next cycle.
- HOLD transitions: `~br` -> GAP. Any further `dma_write` sets `proto_err`.
- GAP transitions: always -> IDLE.
- `offset` = line counter, held for the whole write cycle. It is 0 whenever `bg`=0.
- The CPU-side select outputs are combinational from `bg` and `cpu_d_req`. There is never a cycle in which both the CPU and DMA enables are active.

## Timing
- Reset values:
  - State = IDLE.
  - `bg`, `sel_dma`, `cpu_stall`, `xfer_done`, `abort`, `proto_err` = 0.
  - `offset` = 0.
- Reset takes effect mid-transfer: `bg` drops the cycle after `reset` is sampled high.
- Grant latency:
  - `br` sampled high with `cpu_mem_busy`=0 -> `bg`=1 at the next edge (1 cycle).
  - If `cpu_mem_busy` is high, `bg` rises 1 cycle after `cpu_mem_busy` is sampled low.
- Release latency: `br` sampled low -> `bg`=0 at the next edge. A re-asserted `br` is not granted until 2 cycles after release (GAP).
- Last write and `br` falling in the same cycle:
  - `xfer_done` pulses; `abort` does not.
  - Next state is GAP.
- `dma_write` is only valid while `bg`=1. It is counted on the edge where it is sampled; back-to-back writes are legal.
- With `NUM_LINES`=3, offsets run 0, 1, 2. The counter never wraps inside a transfer.

## Structure
- Shared package:
  - State encoding typedef.
  - `WORD_SIZE`=16 and `LINE_WORDS`=4 constants, shared with the memory model and the DMA engine.
- Sub-module `line_counter`: a saturating, clearable up-counter with terminal-count flag. It is instantiated once for `offset`.
- The FSM and the select logic stay in `dma_bus_arbiter`.

## Test plan
- Clean transfer:
  - Stimulus: `br`=1 at cycle 2 with CPU idle; `dma_write` at cycles 4, 5, 6.
  - Required: `bg`=1 from cycle 3; `offset` = 0, 1, 2; `xfer_done` at cycle 7.
  - `br` dropped at cycle 8 -> `bg`=0 at 9.
- CPU busy: `br`=1 while `cpu_mem_busy`=1 for 4 cycles -> `bg` stays 0 and rises 1 cycle after busy falls.
- Stall and selects: `cpu_d_req`=1 during GRANT -> `cpu_stall`=1 and `cpu_rd_en`=`cpu_wr_en`=0 every granted cycle.
- Abort:
  - Stimulus: `br` drops after 1 write.
  - Required: `abort` pulses once, no `xfer_done`, `offset` returns to 0.
  - Required: with `br` reasserted immediately, the grant is delayed by GAP (2 cycles).
- Protocol error and reset:
  - A `dma_write` in IDLE -> `proto_err` = 1 and stays 1.
  - `reset` during GRANT -> all outputs 0 the next cycle, including `proto_err`.
